fifo_agent_driver: RTL
======================

// Module: fifo_agent_driver
// PURPOSE
//  Producer/consumer end of the fifo under RL test. Accepts action commands from the agent
//  over a valid/ready handshake and expands each into push/pop cycles on the fifo. Tracks
//  occupancy, scores full/empty edge events into a per-action reward and ends episodes.
// PARAMETERS
//  WIDTH        8   fifo data width
//  DEPTH        8   fifo depth; must match the fifo instance
//  LOG2DEPTH    3   clog2(DEPTH)
//  LENW         4   act_len width; one action = act_len+1 cycles (1..16)
//  MAX_STEPS    32  actions per episode before forced episode_done
//  STEP_COST    1   reward subtracted per action
//  REWARD_FULL  10  added on first full_posedge of the episode
//  REWARD_EMPTY 20  added on first empty_posedge after full was hit in the episode
//  RW           8   reward width (two's complement)
// PORTS
//  clk            in   1          clock
//  rst            in   1          reset, asynchronous active-high
//  act_valid      in   1          action offered
//  act_ready      out  1          driver can accept action
//  act_code       in   2          00 IDLE, 01 PUSH, 10 POP, 11 PUSH_POP
//  act_len        in   LENW       cycles minus one
//  push           out  1          fifo push
//  pop            out  1          fifo pop
//  datain         out  WIDTH      fifo write data
//  full           in   1          fifo full
//  empty          in   1          fifo empty
//  full_posedge   in   1          fifo full rising-edge pulse
//  empty_posedge  in   1          fifo empty rising-edge pulse
//  reward         out  RW         signed reward of the last action
//  reward_valid   out  1          one-cycle strobe qualifying reward
//  episode_done   out  1          one-cycle strobe, with reward_valid, on episode end
//  step_count     out  LENW+2     actions completed in current episode
//  occ            out  LOG2DEPTH+1 shadow occupancy
//  err            out  1          sticky: shadow occupancy disagrees with fifo flags
// BEHAVIOUR
//  Reset: all outputs 0 except act_ready=1; occ=0; datain=0; FSM IDLE; episode flags cleared.
//  FSM IDLE->RUN->REPORT->IDLE. act_ready=1 only in IDLE. Transfer = act_valid&act_ready;
//   on transfer latch code, load cycle counter with act_len, go RUN next cycle.
//  RUN: push/pop are registered outputs (asserted the cycle after decision).
//   push requested by code[0], suppressed when occ==DEPTH unless pop also issued this cycle.
//   pop requested by code[1], suppressed when occ==0.
//   PUSH_POP on empty: push only. PUSH_POP on full: both issued.
//   Gating uses occ only; full/empty inputs never gate push/pop (avoids comb loop through fifo).
//   occ += push-pop each issued cycle; never exceeds DEPTH or underflows.
//   datain = running WIDTH-bit counter, increments after each issued push, wraps 2^WIDTH-1->0.
//   Counter reaches 0 -> REPORT. IDLE code spends act_len+1 cycles with no push/pop.
//  Events: full_posedge/empty_posedge sampled every clock in RUN and the first REPORT cycle
//   (covers last issued cycle); hit_full set on first full event; hit_empty set on first
//   empty event while hit_full=1. Repeats in same episode score nothing.
//  REPORT (1 cycle): reward = bonuses newly earned this action - STEP_COST, saturated to RW;
//   reward_valid=1; step_count+1. episode_done=1 if hit_full&hit_empty or step_count+1==
//   MAX_STEPS; then step_count, hit_full, hit_empty clear. occ/datain persist across episodes.
//  err: in IDLE, set if (occ==DEPTH)!=full or (occ==0)!=empty; only rst clears it.
//  Reset mid-action: push/pop drop immediately (async), action discarded, no reward emitted.
// STRUCTURE
//  fifo_rl_pkg: act_code enum (ACT_IDLE/PUSH/POP/PUSH_POP), fsm state enum, reward type.
//  Sub-module fifo_occ_tracker: occ counter with push/pop gating and flag cross-check (err).
// TESTING (DEPTH=8, defaults)
//  Reset mid-RUN of PUSH len=5 -> push=0 same cycle, act_ready=1 after release, occ=0, no reward_valid.
//  PUSH act_len=8 from empty -> 8 pushes, datain 0..7, 9th suppressed, occ=8, reward=+9.
//  Then POP act_len=7 -> 8 pops, occ=0, reward=+19, episode_done=1, step_count->0.
//  POP act_len=0 at occ=0 -> no pop, no empty_posedge, reward=-1.
//  PUSH_POP act_len=3 at occ=3 -> 4 cycles push=pop=1, occ stays 3, datain +4.
//  MAX_STEPS=4, four IDLE actions -> reward=-1 each, episode_done on 4th; forced flag mismatch -> err=1.

Source files
------------

// File: rtl/fifo_rl_pkg.sv
// Shared types for the fifo RL driver: agent action codes, driver FSM states, reward type.
// Also holds a small clamp helper used for reward saturation.
package fifo_rl_pkg;

   typedef enum logic [1:0] {
      ACT_IDLE     = 2'b00,
      ACT_PUSH     = 2'b01,
      ACT_POP      = 2'b10,
      ACT_PUSH_POP = 2'b11
   } act_code_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_REPORT = 2'b10
   } state_t;

   localparam int RW_DEF = 8;
   typedef logic signed [RW_DEF-1:0] reward_t;

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/fifo_occ_tracker.sv
// Shadow occupancy of the fifo: gates push/pop from occ alone (never from fifo flags)
// and raises a sticky err when occ disagrees with full/empty while the driver is idle.
module fifo_occ_tracker #(
   parameter int DEPTH     = 8,
   parameter int LOG2DEPTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic                 push_req,
   input  logic                 pop_req,
   input  logic                 check,
   input  logic                 full,
   input  logic                 empty,
   output logic                 push_go,
   output logic                 pop_go,
   output logic [LOG2DEPTH:0]   occ,
   output logic                 err
);

   localparam int OW = LOG2DEPTH + 1;
   localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH);

   // A push at full is still legal when a pop leaves in the same cycle.
   always_comb begin
      pop_go  = run & pop_req & (occ != '0);
      push_go = run & push_req & ((occ != OCC_MAX) | pop_go);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ <= '0;
         err <= 1'b0;
      end else begin
         occ <= occ + OW'(push_go) - OW'(pop_go);
         if (check && (((occ == OCC_MAX) != full) || ((occ == '0) != empty)))
            err <= 1'b1;
      end
   end

endmodule

// File: rtl/fifo_agent_driver.sv
// Expands agent actions into fifo push/pop cycles and scores full/empty events into a reward.
// Accepts one action at a time (act_ready only in IDLE); reward is shown during the REPORT cycle.
module fifo_agent_driver
   import fifo_rl_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 8,
   parameter int LOG2DEPTH    = 3,
   parameter int LENW         = 4,
   parameter int MAX_STEPS    = 32,
   parameter int STEP_COST    = 1,
   parameter int REWARD_FULL  = 10,
   parameter int REWARD_EMPTY = 20,
   parameter int RW           = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   act_valid,
   output logic                   act_ready,
   input  logic [1:0]             act_code,
   input  logic [LENW-1:0]        act_len,
   output logic                   push,
   output logic                   pop,
   output logic [WIDTH-1:0]       datain,
   input  logic                   full,
   input  logic                   empty,
   input  logic                   full_posedge,
   input  logic                   empty_posedge,
   output logic signed [RW-1:0]   reward,
   output logic                   reward_valid,
   output logic                   episode_done,
   output logic [LENW+1:0]        step_count,
   output logic [LOG2DEPTH:0]     occ,
   output logic                   err
);

   localparam int SW   = LENW + 2;
   localparam int RMAX = (2 ** (RW - 1)) - 1;
   localparam int RMIN = -(2 ** (RW - 1));

   state_t          state, state_nx;
   act_code_t       code_q;
   logic [LENW-1:0] cnt;
   logic            hit_full, hit_empty, got_full, got_empty;
   logic            run, xfer, ev_win, push_req, pop_req, push_go, pop_go;
   logic            new_full, new_empty, earned_full, earned_empty, done_cond;
   logic [SW-1:0]   step_nx;
   int              raw;

   always_comb begin
      state_nx     = state;
      act_ready    = 1'b0;
      xfer         = 1'b0;
      run          = 1'b0;
      ev_win       = 1'b0;
      push_req     = 1'b0;
      pop_req      = 1'b0;
      new_full     = 1'b0;
      new_empty    = 1'b0;
      earned_full  = 1'b0;
      earned_empty = 1'b0;
      done_cond    = 1'b0;
      step_nx      = '0;
      raw          = 0;
      reward_valid = 1'b0;
      episode_done = 1'b0;
      reward       = '0;

      unique case (state)
         ST_IDLE:   if (act_valid) state_nx = ST_RUN;
         ST_RUN:    if (cnt == '0) state_nx = ST_REPORT;
         ST_REPORT: state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase

      act_ready = (state == ST_IDLE);
      xfer      = act_valid & act_ready;
      run       = (state == ST_RUN);
      push_req  = (code_q == ACT_PUSH) || (code_q == ACT_PUSH_POP);
      pop_req   = (code_q == ACT_POP)  || (code_q == ACT_PUSH_POP);

      // The REPORT cycle still shows the last issued push/pop, so its edge pulses count.
      ev_win       = run | (state == ST_REPORT);
      new_full     = ev_win & full_posedge & ~hit_full;
      new_empty    = ev_win & empty_posedge & hit_full & ~hit_empty;
      earned_full  = got_full | new_full;
      earned_empty = got_empty | new_empty;

      step_nx   = step_count + SW'(1);
      done_cond = ((hit_full | new_full) & (hit_empty | new_empty)) |
                  (step_nx == SW'(MAX_STEPS));
      raw = (earned_full ? REWARD_FULL : 0) + (earned_empty ? REWARD_EMPTY : 0) - STEP_COST;

      reward_valid = (state == ST_REPORT);
      episode_done = reward_valid & done_cond;
      if (reward_valid) reward = RW'(clamp(raw, RMIN, RMAX));
   end

   fifo_occ_tracker #(
      .DEPTH     (DEPTH),
      .LOG2DEPTH (LOG2DEPTH)
   ) u_occ (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .push_req (push_req),
      .pop_req  (pop_req),
      .check    (state == ST_IDLE),
      .full     (full),
      .empty    (empty),
      .push_go  (push_go),
      .pop_go   (pop_go),
      .occ      (occ),
      .err      (err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         code_q     <= ACT_IDLE;
         cnt        <= '0;
         push       <= 1'b0;
         pop        <= 1'b0;
         datain     <= '0;
         step_count <= '0;
         hit_full   <= 1'b0;
         hit_empty  <= 1'b0;
         got_full   <= 1'b0;
         got_empty  <= 1'b0;
      end else begin
         state <= state_nx;
         push  <= push_go;
         pop   <= pop_go;
         if (push) datain <= datain + WIDTH'(1);

         if (xfer) begin
            code_q    <= act_code_t'(act_code);
            cnt       <= act_len;
            got_full  <= 1'b0;
            got_empty <= 1'b0;
         end

         if (run) begin
            if (cnt != '0) cnt <= cnt - LENW'(1);
            if (new_full) begin
               hit_full <= 1'b1;
               got_full <= 1'b1;
            end
            if (new_empty) begin
               hit_empty <= 1'b1;
               got_empty <= 1'b1;
            end
         end

         if (state == ST_REPORT) begin
            if (done_cond) begin
               step_count <= '0;
               hit_full   <= 1'b0;
               hit_empty  <= 1'b0;
            end else begin
               step_count <= step_nx;
               hit_full   <= hit_full | new_full;
               hit_empty  <= hit_empty | new_empty;
            end
         end
      end
   end

endmodule
